// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-port memory between instruction fetch and data access.
// Data wins by default; a waiting fetch wins once it has been passed over STARVE_LIMIT times in a row.
module mem_arbiter #(
    parameter int DATA_WIDTH_POW = 6,
    parameter int ADDR_WIDTH_POW = 6,
    parameter int STARVE_LIMIT   = 4,
    localparam int DATA_WIDTH    = 1 << DATA_WIDTH_POW,
    localparam int ADDR_WIDTH    = 1 << ADDR_WIDTH_POW
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic                  ifReq_in,
    input  logic [ADDR_WIDTH-1:0] ifAddr_in,
    output logic                  ifGnt_out,
    output logic                  ifRvalid_out,
    output logic [31:0]           ifRdata_out,
    input  logic                  dReq_in,
    input  logic                  dWe_in,
    input  logic [ADDR_WIDTH-1:0] dAddr_in,
    input  logic [DATA_WIDTH-1:0] dWdata_in,
    output logic                  dGnt_out,
    output logic                  dRvalid_out,
    output logic [DATA_WIDTH-1:0] dRdata_out,
    output logic                  memReq_out,
    output logic                  memWe_out,
    output logic [ADDR_WIDTH-1:0] memAddr_out,
    output logic [DATA_WIDTH-1:0] memWdata_out,
    input  logic [DATA_WIDTH-1:0] memRdata_in
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    // Handshake: a requester holds req until it sees its grant in the same cycle;
    // the grant accepts the request, and a read returns Rvalid exactly one cycle later.
    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DATA  = 2'd2
    } owner_t;

    owner_t          owner;
    logic            owner_hi_word;
    logic [CW-1:0]   starve_cnt;
    logic            at_limit;
    logic            if_gnt;
    logic            d_gnt;

    assign at_limit = (starve_cnt == CW'(STARVE_LIMIT));

    // Grants are forced low while reset is held so nothing reaches the memory.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (reset) begin
            if_gnt = ifReq_in & (~dReq_in | at_limit);
            d_gnt  = dReq_in & ~if_gnt;
        end
    end

    assign ifGnt_out    = if_gnt;
    assign dGnt_out     = d_gnt;
    assign memReq_out   = if_gnt | d_gnt;
    assign memWe_out    = d_gnt & dWe_in;
    assign memAddr_out  = if_gnt ? ifAddr_in : dAddr_in;
    assign memWdata_out = dWdata_in;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            starve_cnt    <= '0;
            owner         <= OWN_NONE;
            owner_hi_word <= 1'b0;
        end else begin
            if (if_gnt || !ifReq_in)
                starve_cnt <= '0;
            else if (d_gnt && !at_limit)
                starve_cnt <= starve_cnt + CW'(1);

            if (if_gnt) begin
                owner         <= OWN_FETCH;
                owner_hi_word <= ifAddr_in[2];
            end else if (d_gnt && !dWe_in) begin
                owner <= OWN_DATA;
            end else begin
                owner <= OWN_NONE;
            end
        end
    end

    assign ifRvalid_out = (owner == OWN_FETCH);
    assign dRvalid_out  = (owner == OWN_DATA);
    assign dRdata_out   = memRdata_in;

    // A wide memory word holds two instructions; address bit 2 picks the half.
    generate
        if (DATA_WIDTH >= 64) begin : g_wide
            assign ifRdata_out = owner_hi_word ? memRdata_in[63:32] : memRdata_in[31:0];
        end else begin : g_narrow
            assign ifRdata_out = memRdata_in[31:0];
        end
    endgenerate

    logic unused_addr_bits;
    assign unused_addr_bits = ^{ifAddr_in[ADDR_WIDTH-1:3], ifAddr_in[1:0]};

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a behavioural model,
// with read returns checked by a separate monitor from an expected-response queue.
module tb_mem_arbiter;

    localparam int DW  = 64;
    localparam int AW  = 64;
    localparam int LIM = 4;

    logic          clk_in = 1'b0;
    logic          reset;
    logic          ifReq_in;
    logic [AW-1:0] ifAddr_in;
    logic          ifGnt_out;
    logic          ifRvalid_out;
    logic [31:0]   ifRdata_out;
    logic          dReq_in;
    logic          dWe_in;
    logic [AW-1:0] dAddr_in;
    logic [DW-1:0] dWdata_in;
    logic          dGnt_out;
    logic          dRvalid_out;
    logic [DW-1:0] dRdata_out;
    logic          memReq_out;
    logic          memWe_out;
    logic [AW-1:0] memAddr_out;
    logic [DW-1:0] memWdata_out;
    logic [DW-1:0] memRdata_in;

    mem_arbiter #(.DATA_WIDTH_POW(6), .ADDR_WIDTH_POW(6), .STARVE_LIMIT(LIM)) dut (
        .clk_in(clk_in), .reset(reset),
        .ifReq_in(ifReq_in), .ifAddr_in(ifAddr_in), .ifGnt_out(ifGnt_out),
        .ifRvalid_out(ifRvalid_out), .ifRdata_out(ifRdata_out),
        .dReq_in(dReq_in), .dWe_in(dWe_in), .dAddr_in(dAddr_in), .dWdata_in(dWdata_in),
        .dGnt_out(dGnt_out), .dRvalid_out(dRvalid_out), .dRdata_out(dRdata_out),
        .memReq_out(memReq_out), .memWe_out(memWe_out), .memAddr_out(memAddr_out),
        .memWdata_out(memWdata_out), .memRdata_in(memRdata_in)
    );

    // clock / cycle counter
    always #5 clk_in = ~clk_in;
    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // memory environment: 16 words indexed by address bits [6:3], one-cycle read latency
    logic [DW-1:0] mem [0:15];
    logic [DW-1:0] rdata_q;
    assign memRdata_in = rdata_q;

    always @(posedge clk_in) begin
        if (memReq_out && memWe_out) mem[memAddr_out[6:3]] <= memWdata_out;
        if (memReq_out && !memWe_out) rdata_q <= mem[memAddr_out[6:3]];
        else rdata_q <= {$urandom, $urandom};
    end

    // scoreboard entry: {due_cycle[15:0], kind[1:0] (1=fetch, 2=data), data[63:0]}
    logic [81:0] exp_q[$];
    int          model_starve = 0;
    logic        exp_if_gnt;
    logic        exp_d_gnt;
    logic [63:0] word;
    logic [15:0] due;

    // reference model: decides the grant from the requests and its own count of passed-over fetches
    always @(negedge clk_in) begin
        if (!reset) begin
            model_starve = 0;
            chk("rst_if_gnt", {63'b0, ifGnt_out}, 64'd0);
            chk("rst_d_gnt", {63'b0, dGnt_out}, 64'd0);
            chk("rst_mem_req", {63'b0, memReq_out}, 64'd0);
            chk("rst_mem_we", {63'b0, memWe_out}, 64'd0);
        end else begin
            exp_if_gnt = ifReq_in && (!dReq_in || model_starve == LIM);
            exp_d_gnt  = dReq_in && !exp_if_gnt;
            chk("if_gnt", {63'b0, ifGnt_out}, {63'b0, exp_if_gnt});
            chk("d_gnt", {63'b0, dGnt_out}, {63'b0, exp_d_gnt});
            chk("mem_req", {63'b0, memReq_out}, {63'b0, exp_if_gnt || exp_d_gnt});
            chk("mem_we", {63'b0, memWe_out}, {63'b0, exp_d_gnt && dWe_in});
            if (exp_if_gnt) chk("mem_addr_fetch", memAddr_out, ifAddr_in);
            if (exp_d_gnt)  chk("mem_addr_data", memAddr_out, dAddr_in);
            if (exp_d_gnt && dWe_in) chk("mem_wdata", memWdata_out, dWdata_in);
            due = 16'(cyc + 1);
            if (exp_if_gnt) begin
                word = mem[ifAddr_in[6:3]];
                exp_q.push_back({due, 2'd1, 32'd0, ifAddr_in[2] ? word[63:32] : word[31:0]});
            end
            if (exp_d_gnt && !dWe_in)
                exp_q.push_back({due, 2'd2, mem[dAddr_in[6:3]]});
            if (exp_if_gnt || !ifReq_in) model_starve = 0;
            else if (exp_d_gnt) model_starve = (model_starve < LIM) ? model_starve + 1 : LIM;
        end
    end

    // monitor: each cycle either the due response is presented or both Rvalids stay low
    logic [81:0] ent;
    always begin
        @(posedge clk_in);
        #2;
        if (exp_q.size() > 0 && exp_q[0][81:66] == 16'(cyc)) begin
            ent = exp_q.pop_front();
            chk("if_rvalid", {63'b0, ifRvalid_out}, {63'b0, ent[65:64] == 2'd1});
            chk("d_rvalid", {63'b0, dRvalid_out}, {63'b0, ent[65:64] == 2'd2});
            if (ent[65:64] == 2'd1) chk("if_rdata", {32'b0, ifRdata_out}, ent[63:0]);
            else chk("d_rdata", dRdata_out, ent[63:0]);
        end else begin
            chk("if_rvalid_idle", {63'b0, ifRvalid_out}, 64'd0);
            chk("d_rvalid_idle", {63'b0, dRvalid_out}, 64'd0);
        end
    end

    // driver: inputs change 1 time unit after the rising edge
    task automatic drive(input logic rst, input logic ir, input logic [AW-1:0] ia,
                         input logic dr, input logic we, input logic [AW-1:0] da,
                         input logic [DW-1:0] wd);
        @(posedge clk_in);
        #1;
        reset = rst; ifReq_in = ir; ifAddr_in = ia;
        dReq_in = dr; dWe_in = we; dAddr_in = da; dWdata_in = wd;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = {$urandom, $urandom};
        rdata_q = '0;
        reset = 1'b0; ifReq_in = 1'b0; ifAddr_in = '0;
        dReq_in = 1'b0; dWe_in = 1'b0; dAddr_in = '0; dWdata_in = '0;
        repeat (3) @(posedge clk_in);
        idle(2);

        // fetch only: low word then high word of the same memory line
        drive(1'b1, 1'b1, 64'h8, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b1, 64'hC, 1'b0, 1'b0, '0, '0);
        idle(2);

        // single load
        drive(1'b1, 1'b0, '0, 1'b1, 1'b0, 64'h100, '0);
        idle(2);

        // both requesting continuously: fetch wins every fifth cycle
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, 64'h40 + 64'(i * 4), 1'b1, 1'b0, 64'h200 + 64'(i * 8), '0);
            #2;
            chk("starve_pattern", {63'b0, ifGnt_out}, {63'b0, (i == 4 || i == 9)});
        end
        idle(2);

        // store then fetch back to back
        drive(1'b1, 1'b0, '0, 1'b1, 1'b1, 64'h18, 64'hDEAD_BEEF_0123_4567);
        drive(1'b1, 1'b1, 64'h1C, 1'b0, 1'b0, '0, '0);
        idle(2);

        // fetch asks twice while data keeps winning, then gives up
        drive(1'b1, 1'b1, 64'h20, 1'b1, 1'b0, 64'h28, '0);
        drive(1'b1, 1'b1, 64'h20, 1'b1, 1'b0, 64'h30, '0);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, '0, 1'b1, 1'b0, 64'h38, '0);
        drive(1'b1, 1'b1, 64'h24, 1'b1, 1'b0, 64'h38, '0);
        idle(2);

        // reset lands in the cycle a load is granted
        drive(1'b1, 1'b0, '0, 1'b1, 1'b0, 64'h48, '0);
        #2;
        chk("pre_reset_d_gnt", {63'b0, dGnt_out}, 64'd1);
        #1;
        reset = 1'b0;
        drive(1'b0, 1'b1, 64'h50, 1'b1, 1'b0, 64'h48, '0);
        drive(1'b0, 1'b1, 64'h50, 1'b1, 1'b0, 64'h48, '0);
        drive(1'b1, 1'b1, 64'h50, 1'b1, 1'b0, 64'h48, '0);
        #2;
        chk("post_reset_d_priority", {63'b0, dGnt_out}, 64'd1);
        idle(2);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'b1, $urandom_range(0, 9) < 6, {$urandom, $urandom},
                  $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3,
                  {$urandom, $urandom}, {$urandom, $urandom});
        end
        idle(4);

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH_POW, default 6, memory data width = 1 << DATA_WIDTH_POW.
REQ-002 SHALL have parameter ADDR_WIDTH_POW, default 6, address width = 1 << ADDR_WIDTH_POW.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, the number of consecutive data grants after which a waiting fetch wins.
REQ-004 SHALL use one clock and an asynchronous, active-low reset: clk_in in 1 (rising-edge clock); reset in 1 (asynchronous, active-low).
REQ-005 ifReq_in  in  1  fetch request, held until granted.
REQ-006 ifAddr_in  in  ADDR_WIDTH  fetch byte address.
REQ-007 ifGnt_out  out  1  fetch request accepted this cycle.
REQ-008 ifRvalid_out / ifRdata_out  out  1 / 32  fetch instruction return.
REQ-009 dReq_in / dWe_in  in  1 / 1  data request, held until granted; 1 = store, 0 = load.
REQ-010 dAddr_in / dWdata_in  in  ADDR_WIDTH / DATA_WIDTH  data address and store data.
REQ-011 dGnt_out  out  1  data request accepted this cycle.
REQ-012 dRvalid_out / dRdata_out  out  1 / DATA_WIDTH  load return.
REQ-013 memReq_out / memWe_out  out  1 / 1  shared single-port memory strobe and write enable.
REQ-014 memAddr_out / memWdata_out  out  ADDR_WIDTH / DATA_WIDTH  memory address and write data.
REQ-015 memRdata_in  in  DATA_WIDTH  read data, valid exactly one cycle after a read strobe.

Function
REQ-016 At most one grant SHALL be asserted per cycle; grants are combinational from the requests and the registered priority state.
REQ-017 Only one requester active: that requester SHALL be granted in the same cycle.
REQ-018 Both active: data SHALL win, unless the starvation counter equals STARVE_LIMIT, in which case fetch SHALL win.
REQ-019 On a grant, memReq_out SHALL be 1, and memAddr_out/memWe_out/memWdata_out SHALL carry the granted port's fields; fetch forces memWe_out=0.
REQ-020 With no grant, memReq_out and memWe_out SHALL be 0.
REQ-021 Starvation counter: +1 (saturating at STARVE_LIMIT) on each cycle data is granted while ifReq_in=1; cleared when fetch is granted or ifReq_in=0.
REQ-022 A granted read SHALL register the owner (fetch or data) and, for fetch, ifAddr_in[2]; the next cycle asserts exactly that owner's Rvalid for one cycle.
REQ-023 ifRdata_out SHALL be memRdata_in[63:32] when the registered addr bit 2 = 1, and memRdata_in[31:0] otherwise (DATA_WIDTH=64); for DATA_WIDTH=32, ifRdata_out = memRdata_in.
REQ-024 dRdata_out SHALL equal memRdata_in.
REQ-025 Stores SHALL produce no Rvalid.
REQ-026 Back-to-back grants SHALL be allowed every cycle: full throughput, 1-cycle read latency, Rvalid pipelined behind the next grant.
REQ-027 Rdata outputs are don't-care when the corresponding Rvalid=0.
REQ-028 Requests deasserted before grant SHALL be dropped without side effects.

Reset
REQ-029 While reset=0, all grants, Rvalids and memReq_out/memWe_out SHALL be 0, the starvation counter 0, and the owner register "none".
REQ-030 A read granted in the cycle reset asserts SHALL return no Rvalid after reset releases.
REQ-031 The first cycle after release SHALL arbitrate normally, with data priority.

Verification
REQ-032 Fetch only, ifAddr=0x8 then 0xC -> ifGnt each cycle; ifRvalid the following cycles with low word then high word of memRdata.
REQ-033 Load only, dAddr=0x100 -> dGnt, memWe=0; dRvalid=1 next cycle and dRdata=memRdata_in; no ifRvalid.
REQ-034 Both requesting continuously, STARVE_LIMIT=4 -> grant pattern D,D,D,D,F,D,D,D,D,F; counter returns to 0 after each F.
REQ-035 Store then fetch back-to-back -> memWe=1 with dWdata in cycle 1; fetch granted cycle 2; only ifRvalid in cycle 3, dRvalid never set.
REQ-036 Reset asserted in the cycle of a granted load -> dRvalid stays 0; outputs all 0 during reset; first post-release request is granted normally.
REQ-037 Fetch requests 2 cycles then drops while data is continuously granted -> counter clears on the drop; no fetch grant and no ifRvalid.
